// File: rtl/delay_pulse_scheduler_pkg.sv
// delay_sched_pkg: FSM state encoding and index helpers shared by the scheduler files.
package delay_sched_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COUNT = 2'd1, ST_FIRE = 2'd2} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/delay_pulse_scheduler_if.sv
// delay_pulse_scheduler_if: request/status bundle; cancel exists only with DELAY_SCHED_CANCEL_EN.
interface delay_pulse_scheduler_if #(parameter int N_CH = 4);
    import delay_sched_pkg::*;
    localparam int CW = clog2(N_CH);
    logic [N_CH-1:0] req;
`ifdef DELAY_SCHED_CANCEL_EN
    logic [N_CH-1:0] cancel;
`endif
    logic [N_CH-1:0] done;
    logic [N_CH-1:0] pending;
    logic busy;
    logic [CW-1:0] active_ch;
`ifdef DELAY_SCHED_CANCEL_EN
    modport master (output req, output cancel, input done, input pending, input busy, input active_ch);
    modport slave (input req, input cancel, output done, output pending, output busy, output active_ch);
`else
    modport master (output req, input done, input pending, input busy, input active_ch);
    modport slave (input req, output done, output pending, output busy, output active_ch);
`endif
endinterface

// File: rtl/delay_pulse_scheduler_rr_arbiter.sv
// rr_arbiter: combinational pick of the first set request at or after the pointer, wrapping.
module rr_arbiter
    import delay_sched_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int CW = clog2(N_CH)
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [CW-1:0]   i_ptr,
    output logic            o_grant_valid,
    output logic [CW-1:0]   o_grant_idx
);
    logic [CW-1:0] w_idx;
    // Scan from the farthest offset down so the nearest hit is the last write.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx = '0;
        w_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_idx = CW'((int'(i_ptr) + k) % N_CH);
            if (i_req[w_idx]) begin
                o_grant_valid = 1'b1;
                o_grant_idx = w_idx;
            end
        end
    end
endmodule

// File: rtl/delay_pulse_scheduler.sv
// delay_pulse_scheduler: one shared delay timer granted round-robin to N_CH latched requests.
// Define DELAY_SCHED_CANCEL_EN to add the per-channel cancel input.
module delay_pulse_scheduler
    import delay_sched_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CLKS_DELAY = 5
) (
    input logic CLK,
    input logic RST,
    delay_pulse_scheduler_if.slave bus
);
    localparam int CW = clog2(N_CH);
    localparam int TW = clog2(CLKS_DELAY + 1);
    state_t r_state, w_next;
    logic [TW-1:0] r_ticks;
    logic [N_CH-1:0] r_pending, r_done, w_clr, w_cancel;
    logic [CW-1:0] r_active, r_ptr, w_sel;
    logic w_valid, w_last, w_abort, w_grant;
`ifdef DELAY_SCHED_CANCEL_EN
    assign w_cancel = bus.cancel;
`else
    assign w_cancel = '0;
`endif
    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .i_req(r_pending),
        .i_ptr(r_ptr),
        .o_grant_valid(w_valid),
        .o_grant_idx(w_sel)
    );
    assign w_grant = r_state == ST_IDLE && w_valid;
    assign w_last = r_ticks == TW'(CLKS_DELAY);
    assign w_abort = r_state == ST_COUNT && w_cancel[r_active];
    assign w_clr = w_grant ? N_CH'(1) << w_sel : '0;
    always_ff @(posedge CLK) r_state <= RST ? ST_IDLE : w_next;
    always_comb begin
        w_next = r_state == ST_IDLE  ? (w_valid ? ST_COUNT : ST_IDLE) :
                 r_state == ST_COUNT ? (w_abort ? ST_IDLE : w_last ? ST_FIRE : ST_COUNT) :
                 ST_IDLE;
    end
    // A request landing on the grant edge re-queues; cancel beats both.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pending <= '0;
            r_done <= '0;
            r_active <= '0;
            r_ptr <= '0;
            r_ticks <= '0;
        end else begin
            r_pending <= ((r_pending & ~w_clr) | bus.req) & ~w_cancel;
            r_done <= (r_state == ST_COUNT && w_last && !w_abort) ? N_CH'(1) << r_active : '0;
            if (w_grant) begin
                r_active <= w_sel;
                r_ticks <= TW'(1);
            end else if (w_abort) begin
                r_ptr <= CW'(rr_next(int'(r_active), N_CH));
                r_ticks <= '0;
            end else if (r_state == ST_COUNT && !w_last) begin
                r_ticks <= r_ticks + TW'(1);
            end else if (r_state == ST_FIRE) begin
                r_ptr <= CW'(rr_next(int'(r_active), N_CH));
            end
        end
    end
    always_comb begin
        bus.done = r_done;
        bus.pending = r_pending;
        bus.busy = r_state != ST_IDLE;
        bus.active_ch = r_active;
    end
endmodule

// File: tb/tb_delay_pulse_scheduler.sv
// tb_delay_pulse_scheduler: vector table, directed corner sequences and random traffic vs a timestamp model.
module tb_delay_pulse_scheduler;
    localparam int N = 4;
    localparam int D = 5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    delay_pulse_scheduler_if #(.N_CH(N)) bus ();
    delay_pulse_scheduler #(.N_CH(N), .CLKS_DELAY(D)) dut (.CLK(clk), .RST(rst), .bus(bus));
    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic       busy;
        int         ch;
        logic [3:0] pend;
    } vec_t;
    vec_t tbl[8];
    int n_cmp = 0, n_bad = 0, k = 0;
    logic [3:0] m_pend, m_done;
    bit m_busy;
    int m_act, m_ptr, t_g;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", n, k, a, e);
        end
    endtask
    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction
    task automatic model_reset();
        m_pend = '0;
        m_done = '0;
        m_busy = 1'b0;
        m_act = 0;
        m_ptr = 0;
        t_g = 0;
    endtask
    // Grant at edge t_g: done follows D edges later, idle one edge after that.
    task automatic model_step(input logic [3:0] r, input logic [3:0] c);
        logic [3:0] old;
        int ch;
        old = m_pend;
        m_done = '0;
        if (m_busy) begin
            if (k == t_g + D + 1) begin
                m_busy = 1'b0;
                m_ptr = (m_act + 1) % N;
            end else if (c[m_act] && k <= t_g + D) begin
                m_busy = 1'b0;
                m_ptr = (m_act + 1) % N;
            end else if (k == t_g + D) begin
                m_done = 4'(1 << m_act);
            end
        end else if (old != 0) begin
            ch = m_ptr;
            while (!old[ch]) ch = (ch + 1) % N;
            m_act = ch;
            t_g = k;
            m_busy = 1'b1;
            old[ch] = 1'b0;
        end
        m_pend = (old | r) & ~c;
    endtask
    task automatic cycle(input logic [3:0] r, input logic [3:0] c);
        bus.req = r;
`ifdef DELAY_SCHED_CANCEL_EN
        bus.cancel = c;
`endif
        @(posedge clk);
        #1;
        k++;
        if (rst) model_reset();
        else model_step(r, c);
        chk("done", bus.done, m_done);
        chk("busy", bus.busy, m_busy);
        chk("active_ch", bus.active_ch, m_act);
        chk("pending", bus.pending, m_pend);
    endtask
    task automatic reset_dut();
        rst = 1'b1;
        repeat (3) cycle(4'h0, 4'h0);
        rst = 1'b0;
    endtask
    int ts[$], cs[$];
    int e3[3] = '{0, 1, 3};
    int t0, cnt;
    logic [3:0] rr, rc;
    initial begin
        bus.req = '0;
`ifdef DELAY_SCHED_CANCEL_EN
        bus.cancel = '0;
`endif
        model_reset();
        tbl[0] = '{4'b0010, 4'b0000, 1'b0, 0, 4'b0010};
        tbl[1] = '{4'b0000, 4'b0000, 1'b1, 1, 4'b0000};
        tbl[2] = '{4'b0000, 4'b0000, 1'b1, 1, 4'b0000};
        tbl[3] = '{4'b0000, 4'b0000, 1'b1, 1, 4'b0000};
        tbl[4] = '{4'b0000, 4'b0000, 1'b1, 1, 4'b0000};
        tbl[5] = '{4'b0000, 4'b0000, 1'b1, 1, 4'b0000};
        tbl[6] = '{4'b0000, 4'b0010, 1'b1, 1, 4'b0000};
        tbl[7] = '{4'b0000, 4'b0000, 1'b0, 1, 4'b0000};
        // 1: reset then quiet
        reset_dut();
        for (int i = 0; i < 20; i++) begin
            cycle(4'h0, 4'h0);
            chk("t1_busy", bus.busy, 1'b0);
            chk("t1_done", bus.done, 4'h0);
        end
        // 2: single request, vector table
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].req, 4'h0);
            chk($sformatf("tbl%0d_done", i), bus.done, tbl[i].done);
            chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
            chk($sformatf("tbl%0d_ch", i), bus.active_ch, tbl[i].ch);
            chk($sformatf("tbl%0d_pend", i), bus.pending, tbl[i].pend);
        end
        // 3: three requests at once, served 0,1,3
        reset_dut();
        cycle(4'b1011, 4'h0);
        t0 = k;
        for (int i = 0; i < 40 && cs.size() < 3; i++) begin
            cycle(4'h0, 4'h0);
            if (bus.done != 0) begin
                ts.push_back(k);
                cs.push_back(oh2idx(bus.done));
            end
        end
        chk("t3_pulses", cs.size(), 3);
        for (int i = 0; i < 3; i++) chk("t3_ch", i < cs.size() ? cs[i] : -1, e3[i]);
        if (ts.size() > 0) chk("t3_latency", ts[0] - t0, D + 1);
        for (int i = 1; i < ts.size(); i++) chk("t3_spacing", ts[i] - ts[i-1], D + 2);
        repeat (3) cycle(4'h0, 4'h0);
        // 4: all held, rotation starting at ch0
        ts.delete();
        cs.delete();
        for (int i = 0; i < 300 && cs.size() < 8; i++) begin
            cycle(4'hF, 4'h0);
            if (bus.done != 0) begin
                ts.push_back(k);
                cs.push_back(oh2idx(bus.done));
            end
        end
        chk("t4_pulses", cs.size(), 8);
        for (int i = 0; i < cs.size(); i++) begin
            chk("t4_ch", cs[i], i % N);
            if (i >= N) chk("t4_period", ts[i] - ts[i-N], N * (D + 2));
        end
        repeat (40) cycle(4'h0, 4'h0);
        // 5: reset in the middle of a count
        reset_dut();
        cycle(4'b0100, 4'h0);
        repeat (3) cycle(4'h0, 4'h0);
        rst = 1'b1;
        cycle(4'h0, 4'h0);
        chk("t5_busy", bus.busy, 1'b0);
        chk("t5_done", bus.done, 4'h0);
        chk("t5_ch", bus.active_ch, 0);
        chk("t5_pend", bus.pending, 4'h0);
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            cycle(4'h0, 4'h0);
            if (bus.done[2]) cnt++;
        end
        chk("t5_no_done", cnt, 0);
        cycle(4'b0001, 4'h0);
        cnt = 0;
        repeat (8) begin
            cycle(4'h0, 4'h0);
            if (bus.done[0]) cnt++;
        end
        chk("t5_new_req", cnt, 1);
`ifdef DELAY_SCHED_CANCEL_EN
        // 6: cancel the active grant at tick 2
        reset_dut();
        cycle(4'b0010, 4'h0);
        cycle(4'b0100, 4'h0);
        cycle(4'h0, 4'h0);
        cycle(4'h0, 4'b0010);
        chk("t6_abort_busy", bus.busy, 1'b0);
        cycle(4'h0, 4'h0);
        chk("t6_regrant_ch", bus.active_ch, 2);
        chk("t6_regrant_busy", bus.busy, 1'b1);
        cnt = 0;
        repeat (10) begin
            cycle(4'h0, 4'h0);
            if (bus.done[1]) cnt++;
        end
        chk("t6_no_done_ch1", cnt, 0);
`endif
        // random traffic against the model
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            rc = 4'h0;
`ifdef DELAY_SCHED_CANCEL_EN
            rc = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
`endif
            cycle(rr, rc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
